// File: rtl/oclib_pkg.sv
// ---------------------------------------------------------------------------
// oclib_pkg
// Shared constants for oclib blocks. True/False stand in for one-bit
// boolean parameters, so instantiations read as flags rather than as bits.
// ---------------------------------------------------------------------------
package oclib_pkg;

  localparam bit True  = 1'b1;
  localparam bit False = 1'b0;

endpackage

// File: rtl/oclib_rv_skid.sv
// ---------------------------------------------------------------------------
// oclib_rv_skid
// One registered valid/ready stage. valid/data are registered forward and
// ready is registered backward. A skid register catches the single beat that
// can arrive while main is stalled, because upstream only sees the ready drop
// one cycle later. The stage runs at full throughput and holds up to 2 beats.
//
// Ports
//   clock      in   rising-edge clock
//   reset      in   synchronous, active-high; clears valids and readyReg
//   inValid    in   upstream beat valid
//   inData     in   upstream beat data [Width]
//   inReady    out  registered ready to upstream
//   outValid   out  downstream beat valid (main register)
//   outData    out  downstream beat data (main register) [Width]
//   outReady   in   downstream accepts beat
// ---------------------------------------------------------------------------
module oclib_rv_skid
  import oclib_pkg::*;
#(
  parameter int Width     = 1,
  parameter bit DontTouch = False
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             inValid,
  input  logic [Width-1:0] inData,
  output logic             inReady,
  output logic             outValid,
  output logic [Width-1:0] outData,
  input  logic             outReady
);

  (* dont_touch = (DontTouch ? "true" : "false") *) logic             r_main_valid;
  (* dont_touch = (DontTouch ? "true" : "false") *) logic [Width-1:0] r_main_data;
  (* dont_touch = (DontTouch ? "true" : "false") *) logic             r_skid_valid;
  (* dont_touch = (DontTouch ? "true" : "false") *) logic [Width-1:0] r_skid_data;
  (* dont_touch = (DontTouch ? "true" : "false") *) logic             r_ready;

  logic w_pop;
  logic w_push;
  logic w_main_free;
  logic w_skid_valid_next;

  assign w_pop       = r_main_valid && outReady;
  assign w_push      = inValid && r_ready;
  // main is free to load whenever it is empty or its beat leaves this edge
  assign w_main_free = w_pop || !r_main_valid;

  // skid only fills when main is full and stalled; ready tracks its next state
  assign w_skid_valid_next = w_main_free ? 1'b0 :
                             (w_push ? 1'b1 : r_skid_valid);

  always_ff @(posedge clock) begin
    if (reset) begin
      r_main_valid <= 1'b0;
      r_skid_valid <= 1'b0;
      r_ready      <= 1'b0;
    end else begin
      if (w_main_free) begin
        r_main_valid <= r_skid_valid || w_push;
      end
      r_skid_valid <= w_skid_valid_next;
      r_ready      <= !w_skid_valid_next;
    end
  end

  // data registers carry no reset; valids qualify them
  always_ff @(posedge clock) begin
    if (w_main_free) begin
      if (r_skid_valid) begin
        r_main_data <= r_skid_data;
      end else if (w_push) begin
        r_main_data <= inData;
      end
    end else if (w_push) begin
      r_skid_data <= inData;
    end
  end

  assign outValid = r_main_valid;
  assign outData  = r_main_data;
  assign inReady  = r_ready;

endmodule

// File: rtl/oclib_rv_pipeline.sv
// ---------------------------------------------------------------------------
// oclib_rv_pipeline
// Retiming pipeline for a valid/ready stream: Length chained oclib_rv_skid
// stages, each registering valid/data forward and ready backward. Length=0 is
// a pure combinational pass-through. Latency Length cycles, 1 beat/cycle,
// capacity 2*Length beats.
//
// Ports
//   clock      in   rising-edge clock
//   reset      in   synchronous, active-high (unused when Length=0)
//   inValid    in   upstream beat valid
//   inData     in   upstream beat data [Width]
//   inReady    out  pipeline can accept a beat
//   outValid   out  downstream beat valid
//   outData    out  downstream beat data [Width]
//   outReady   in   downstream accepts beat
// ---------------------------------------------------------------------------
module oclib_rv_pipeline
  import oclib_pkg::*;
#(
  parameter int Width     = 1,
  parameter int Length    = 1,
  parameter bit DontTouch = False
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             inValid,
  input  logic [Width-1:0] inData,
  output logic             inReady,
  output logic             outValid,
  output logic [Width-1:0] outData,
  input  logic             outReady
);

  if (Length == 0) begin : g_bypass
    assign outValid = inValid;
    assign outData  = inData;
    assign inReady  = outReady;
  end else begin : g_chain
    // index i is the interface between stage i-1 and stage i
    logic             w_valid [Length+1];
    logic [Width-1:0] w_data  [Length+1];
    logic             w_ready [Length+1];

    assign w_valid[0]      = inValid;
    assign w_data[0]       = inData;
    assign inReady         = w_ready[0];
    assign outValid        = w_valid[Length];
    assign outData         = w_data[Length];
    assign w_ready[Length] = outReady;

    for (genvar i = 0; i < Length; i++) begin : g_stage
      oclib_rv_skid #(
        .Width     (Width),
        .DontTouch (DontTouch)
      ) u_stage (
        .clock    (clock),
        .reset    (reset),
        .inValid  (w_valid[i]),
        .inData   (w_data[i]),
        .inReady  (w_ready[i]),
        .outValid (w_valid[i+1]),
        .outData  (w_data[i+1]),
        .outReady (w_ready[i+1])
      );
    end
  end

endmodule

// File: tb/tb_oclib_rv_pipeline.sv
module tb_oclib_rv_pipeline;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Length=3, Width=8
  logic       a_iv = 1'b0, a_ir, a_ov, a_or = 1'b0;
  logic [7:0] a_id = '0, a_od;
  // Length=0, Width=8
  logic       z_iv = 1'b0, z_ir, z_ov, z_or = 1'b0;
  logic [7:0] z_id = '0, z_od;
  // Length=2, Width=8
  logic       m_iv = 1'b0, m_ir, m_ov, m_or = 1'b0;
  logic [7:0] m_id = '0, m_od;
  // Width=32, Length=1,2,5
  logic        r_iv [3];
  logic        r_ir [3];
  logic        r_ov [3];
  logic        r_or [3];
  logic [31:0] r_id [3];
  logic [31:0] r_od [3];

  oclib_rv_pipeline #(.Width(8), .Length(3)) u_a (
    .clock(clk), .reset(rst), .inValid(a_iv), .inData(a_id), .inReady(a_ir),
    .outValid(a_ov), .outData(a_od), .outReady(a_or));

  oclib_rv_pipeline #(.Width(8), .Length(0)) u_z (
    .clock(clk), .reset(rst), .inValid(z_iv), .inData(z_id), .inReady(z_ir),
    .outValid(z_ov), .outData(z_od), .outReady(z_or));

  oclib_rv_pipeline #(.Width(8), .Length(2)) u_m (
    .clock(clk), .reset(rst), .inValid(m_iv), .inData(m_id), .inReady(m_ir),
    .outValid(m_ov), .outData(m_od), .outReady(m_or));

  for (genvar g = 0; g < 3; g++) begin : g_rand
    oclib_rv_pipeline #(.Width(32), .Length((g == 0) ? 1 : ((g == 1) ? 2 : 5))) u_r (
      .clock(clk), .reset(rst), .inValid(r_iv[g]), .inData(r_id[g]), .inReady(r_ir[g]),
      .outValid(r_ov[g]), .outData(r_od[g]), .outReady(r_or[g]));
  end

  task automatic test_reset();
    for (int i = 0; i < 3; i++) begin
      r_iv[i] = 1'b0; r_or[i] = 1'b0; r_id[i] = '0;
    end
    rst  = 1'b1;
    a_iv = 1'b1;
    a_id = 8'h55;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      checks++;
      if (a_ov !== 1'b0 || a_ir !== 1'b0) begin
        errors++;
        $display("FAIL reset_hold cyc %0d: outValid=%b inReady=%b, required 0 0", c, a_ov, a_ir);
      end
    end
    rst  = 1'b0;
    a_iv = 1'b0;
    #1;
    checks++;
    if (a_ir !== 1'b0) begin
      errors++;
      $display("FAIL reset_first_cycle: inReady=%b, required 0", a_ir);
    end
    @(negedge clk);
    checks++;
    if (a_ir !== 1'b1 || a_ov !== 1'b0) begin
      errors++;
      $display("FAIL reset_after: inReady=%b outValid=%b, required 1 0", a_ir, a_ov);
    end
  endtask

  task automatic test_streaming();
    int n_out = 0;
    a_or = 1'b1;
    for (int k = 0; k < 22; k++) begin
      @(negedge clk);
      if (a_ov === 1'b1) begin
        checks++;
        if (a_od !== 8'(n_out) || k != n_out + 3) begin
          errors++;
          $display("FAIL stream_beat: data=%0d at iter %0d, required %0d at iter %0d",
                   a_od, k, n_out, n_out + 3);
        end
        n_out++;
      end
      a_iv = (k < 16);
      a_id = 8'(k);
      if (k < 16) begin
        checks++;
        if (a_ir !== 1'b1) begin
          errors++;
          $display("FAIL stream_ready iter %0d: inReady=%b, required 1", k, a_ir);
        end
      end
    end
    a_iv = 1'b0;
    checks++;
    if (n_out != 16) begin
      errors++;
      $display("FAIL stream_count: got %0d beats, required 16", n_out);
    end
  endtask

  task automatic test_fill_drain();
    int acc = 0;
    bit seen;
    a_or = 1'b0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      a_iv = 1'b1;
      a_id = 8'(acc);
      if (a_ir === 1'b1) acc++;
    end
    checks++;
    if (acc != 6 || a_ir !== 1'b0) begin
      errors++;
      $display("FAIL fill_capacity: accepted %0d inReady=%b, required 6 0", acc, a_ir);
    end
    for (int j = 0; j < 7; j++) begin
      @(negedge clk);
      a_iv = 1'b0;
      a_or = 1'b1;
      checks++;
      if (j < 6) begin
        if (a_ov !== 1'b1 || a_od !== 8'(j)) begin
          errors++;
          $display("FAIL drain_beat %0d: outValid=%b data=%0d, required 1 %0d", j, a_ov, a_od, j);
        end
      end else if (a_ov !== 1'b0) begin
        errors++;
        $display("FAIL drain_empty: outValid=%b, required 0", a_ov);
      end
    end
    seen = 1'b0;
    for (int w = 0; w < 10 && !seen; w++) begin
      @(negedge clk);
      if (a_ir === 1'b1) seen = 1'b1;
    end
    checks++;
    if (!seen) begin
      errors++;
      $display("FAIL drain_ready: inReady=%b after drain, required 1", a_ir);
    end
  endtask

  task automatic test_random();
    localparam int N = 10000;
    logic [31:0] sb [3][$];
    int          sent [3];
    int          got  [3];
    bit          prev_stall [3];
    bit          hold_in [3];
    logic [31:0] prev_data [3];
    logic [31:0] exp_d;
    int          cyc = 0;
    for (int i = 0; i < 3; i++) begin
      sent[i] = 0; got[i] = 0; prev_stall[i] = 1'b0; hold_in[i] = 1'b0; prev_data[i] = '0;
    end
    while ((got[0] < N || got[1] < N || got[2] < N) && cyc < 40000) begin
      @(negedge clk);
      cyc++;
      for (int i = 0; i < 3; i++) begin
        if (prev_stall[i]) begin
          checks++;
          if (r_ov[i] !== 1'b1 || r_od[i] !== prev_data[i]) begin
            errors++;
            $display("FAIL rand_hold dut %0d: outValid=%b data=%h, required 1 %h",
                     i, r_ov[i], r_od[i], prev_data[i]);
          end
        end
        if (!hold_in[i]) begin
          if (sent[i] < N && $urandom_range(0, 3) != 0) begin
            r_iv[i] = 1'b1;
            r_id[i] = $urandom;
          end else begin
            r_iv[i] = 1'b0;
          end
        end
        r_or[i] = ($urandom_range(0, 3) != 0);
        if (r_ov[i] === 1'b1 && r_or[i]) begin
          checks++;
          if (sb[i].size() == 0) begin
            errors++;
            $display("FAIL rand_extra dut %0d: data=%h emitted, required none", i, r_od[i]);
          end else begin
            exp_d = sb[i].pop_front();
            if (r_od[i] !== exp_d) begin
              errors++;
              $display("FAIL rand_data dut %0d beat %0d: data=%h, required %h", i, got[i], r_od[i], exp_d);
            end
          end
          got[i]++;
        end
        if (r_iv[i] && r_ir[i] === 1'b1) begin
          sb[i].push_back(r_id[i]);
          sent[i]++;
        end
        prev_stall[i] = (r_ov[i] === 1'b1) && !r_or[i];
        prev_data[i]  = r_od[i];
        hold_in[i]    = r_iv[i] && (r_ir[i] !== 1'b1);
      end
    end
    for (int i = 0; i < 3; i++) begin
      r_iv[i] = 1'b0;
      checks++;
      if (got[i] != N || sb[i].size() != 0) begin
        errors++;
        $display("FAIL rand_count dut %0d: got %0d beats (%0d left), required %0d (0 left)",
                 i, got[i], sb[i].size(), N);
      end
    end
  endtask

  task automatic test_length0();
    logic [9:0] vec [6];
    vec[0] = {1'b1, 8'h3C, 1'b0};
    vec[1] = {1'b1, 8'h3C, 1'b1};
    vec[2] = {1'b0, 8'hA5, 1'b1};
    vec[3] = {1'b0, 8'h00, 1'b0};
    vec[4] = {1'b1, 8'hFF, 1'b1};
    vec[5] = {1'b1, 8'h81, 1'b0};
    for (int v = 0; v < 6; v++) begin
      @(negedge clk);
      z_iv = vec[v][9];
      z_id = vec[v][8:1];
      z_or = vec[v][0];
      #1;
      checks++;
      if (z_ir !== vec[v][0] || z_ov !== vec[v][9] || z_od !== vec[v][8:1]) begin
        errors++;
        $display("FAIL len0_vec %0d: inReady=%b outValid=%b data=%h, required %b %b %h",
                 v, z_ir, z_ov, z_od, vec[v][0], vec[v][9], vec[v][8:1]);
      end
    end
  endtask

  task automatic test_midstream_reset();
    int acc = 0;
    int n_out = 0;
    m_or = 1'b0;
    for (int k = 0; k < 20 && acc < 4; k++) begin
      @(negedge clk);
      m_iv = 1'b1;
      m_id = 8'h10 + 8'(acc);
      if (m_ir === 1'b1) acc++;
    end
    @(negedge clk);
    m_iv = 1'b0;
    checks++;
    if (acc != 4 || m_ov !== 1'b1) begin
      errors++;
      $display("FAIL mid_fill: accepted %0d outValid=%b, required 4 1", acc, m_ov);
    end
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    checks++;
    if (m_ov !== 1'b0 || m_ir !== 1'b0) begin
      errors++;
      $display("FAIL mid_reset: outValid=%b inReady=%b, required 0 0", m_ov, m_ir);
    end
    acc = 0;
    m_or = 1'b1;
    for (int k = 0; k < 40 && n_out < 8; k++) begin
      @(negedge clk);
      if (m_ov === 1'b1) begin
        checks++;
        if (m_od !== 8'hA0 + 8'(n_out)) begin
          errors++;
          $display("FAIL mid_stream beat %0d: data=%h, required %h", n_out, m_od, 8'hA0 + 8'(n_out));
        end
        n_out++;
      end
      m_iv = (acc < 8);
      m_id = 8'hA0 + 8'(acc);
      if (m_iv && m_ir === 1'b1) acc++;
    end
    m_iv = 1'b0;
    checks++;
    if (n_out != 8) begin
      errors++;
      $display("FAIL mid_count: got %0d beats, required 8", n_out);
    end
  endtask

  initial begin
    test_reset();
    test_streaming();
    test_fill_drain();
    test_length0();
    test_midstream_reset();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
